// File: rtl/missile_bren_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : missile_bren_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one Bresenham line engine
//            between three missile controllers. Grants one requester, loads
//            its endpoints, pulses the engine start, routes the point stream
//            back and closes on engine done, requester abort or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module missile_bren_arbiter #(
  parameter int OUT_WIDTH = 8,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req,
  input  logic [3*OUT_WIDTH-1:0] xstart_bus,
  input  logic [3*OUT_WIDTH-1:0] ystart_bus,
  input  logic [3*OUT_WIDTH-1:0] xend_bus,
  input  logic [3*OUT_WIDTH-1:0] yend_bus,
  output logic [2:0]             gnt,
  output logic [2:0]             done,
  output logic                   timeout,
  output logic                   bren_start,
  output logic                   bren_abort,
  output logic [OUT_WIDTH-1:0]   x0,
  output logic [OUT_WIDTH-1:0]   y0,
  output logic [OUT_WIDTH-1:0]   x1,
  output logic [OUT_WIDTH-1:0]   y1,
  input  logic                   bren_point_valid,
  input  logic [OUT_WIDTH-1:0]   bren_x,
  input  logic [OUT_WIDTH-1:0]   bren_y,
  input  logic                   bren_done,
  output logic [2:0]             pos_valid,
  output logic [OUT_WIDTH-1:0]   xpos,
  output logic [OUT_WIDTH-1:0]   ypos
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  // Three-bit encoding leaves spare codes; any of them recovers to IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t                r_state;
  logic [1:0]            r_ptr;
  logic [1:0]            r_idx;
  logic [15:0]           r_cnt;

  state_t                w_state_nx;
  logic [1:0]            w_ptr_nx;
  logic [1:0]            w_idx_nx;
  logic [15:0]           w_cnt_nx;
  logic [2:0]            w_gnt_nx;
  logic [2:0]            w_done_nx;
  logic                  w_timeout_nx;
  logic                  w_start_nx;
  logic                  w_abort_nx;
  logic [OUT_WIDTH-1:0]  w_x0_nx;
  logic [OUT_WIDTH-1:0]  w_y0_nx;
  logic [OUT_WIDTH-1:0]  w_x1_nx;
  logic [OUT_WIDTH-1:0]  w_y1_nx;

  logic [1:0]            w_cand0;
  logic [1:0]            w_cand1;
  logic [1:0]            w_cand2;
  logic                  w_win_found;
  logic [1:0]            w_win_idx;

  // Safe single-bit select of a 3-bit vector with a 2-bit index.
  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] i);
    case (i)
      2'd0:    bit_at = vec[0];
      2'd1:    bit_at = vec[1];
      2'd2:    bit_at = vec[2];
      default: bit_at = 1'b0;
    endcase
  endfunction

  // Requester-slice select from a packed three-slot coordinate bus.
  function automatic logic [OUT_WIDTH-1:0] slice_at(input logic [3*OUT_WIDTH-1:0] bus,
                                                    input logic [1:0]             i);
    case (i)
      2'd0:    slice_at = bus[0*OUT_WIDTH +: OUT_WIDTH];
      2'd1:    slice_at = bus[1*OUT_WIDTH +: OUT_WIDTH];
      2'd2:    slice_at = bus[2*OUT_WIDTH +: OUT_WIDTH];
      default: slice_at = '0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] inc_mod3(input logic [1:0] i);
    inc_mod3 = (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin winner: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    w_cand0     = r_ptr;
    w_cand1     = inc_mod3(r_ptr);
    w_cand2     = inc_mod3(w_cand1);
    w_win_found = 1'b1;
    w_win_idx   = 2'd0;
    if (bit_at(req, w_cand0)) begin
      w_win_idx = w_cand0;
    end else if (bit_at(req, w_cand1)) begin
      w_win_idx = w_cand1;
    end else if (bit_at(req, w_cand2)) begin
      w_win_idx = w_cand2;
    end else begin
      w_win_found = 1'b0;
    end
  end

  // Next-state and next-output logic; pulses default low, levels hold.
  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_idx_nx     = r_idx;
    w_cnt_nx     = r_cnt;
    w_gnt_nx     = gnt;
    w_done_nx    = 3'b000;
    w_timeout_nx = 1'b0;
    w_start_nx   = 1'b0;
    w_abort_nx   = 1'b0;
    w_x0_nx      = x0;
    w_y0_nx      = y0;
    w_x1_nx      = x1;
    w_y1_nx      = y1;

    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_idx_nx   = w_win_idx;
          w_gnt_nx   = onehot(w_win_idx);
          w_x0_nx    = slice_at(xstart_bus, w_win_idx);
          w_y0_nx    = slice_at(ystart_bus, w_win_idx);
          w_x1_nx    = slice_at(xend_bus,   w_win_idx);
          w_y1_nx    = slice_at(yend_bus,   w_win_idx);
          w_start_nx = 1'b1;
          w_cnt_nx   = 16'd0;
          w_state_nx = S_START;
        end
      end

      S_START: begin
        w_state_nx = S_RUN;
      end

      S_RUN: begin
        if (r_cnt != C_CNT_MAX) begin
          w_cnt_nx = r_cnt + 16'd1;
        end
        // Engine completion wins over a same-cycle abort, abort over timeout.
        if (bren_done) begin
          w_done_nx  = onehot(r_idx);
          w_gnt_nx   = 3'b000;
          w_state_nx = S_DONE;
        end else if (!bit_at(req, r_idx)) begin
          w_abort_nx = 1'b1;
          w_gnt_nx   = 3'b000;
          w_state_nx = S_DONE;
        end else if (r_cnt == C_TIMEOUT) begin
          w_abort_nx   = 1'b1;
          w_timeout_nx = 1'b1;
          w_gnt_nx     = 3'b000;
          w_state_nx   = S_DONE;
        end
      end

      S_DONE: begin
        w_gnt_nx   = 3'b000;
        w_ptr_nx   = inc_mod3(r_idx);
        w_state_nx = S_IDLE;
      end

      default: begin
        w_gnt_nx   = 3'b000;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, bookkeeping and control outputs register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_idx      <= 2'd0;
      r_cnt      <= 16'd0;
      gnt        <= 3'b000;
      done       <= 3'b000;
      timeout    <= 1'b0;
      bren_start <= 1'b0;
      bren_abort <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_idx      <= w_idx_nx;
      r_cnt      <= w_cnt_nx;
      gnt        <= w_gnt_nx;
      done       <= w_done_nx;
      timeout    <= w_timeout_nx;
      bren_start <= w_start_nx;
      bren_abort <= w_abort_nx;
      x0         <= w_x0_nx;
      y0         <= w_y0_nx;
      x1         <= w_x1_nx;
      y1         <= w_y1_nx;
    end
  end

  // Point stream copy; strobes only reach the currently granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_valid <= 3'b000;
      xpos      <= '0;
      ypos      <= '0;
    end else begin
      pos_valid <= gnt & {3{bren_point_valid}};
      xpos      <= bren_x;
      ypos      <= bren_y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_missile_bren_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_missile_bren_arbiter
// Purpose  : Self-checking bench for missile_bren_arbiter: transaction table,
//            directed corner sequences and randomized traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_missile_bren_arbiter;

  localparam int W       = 8;
  localparam int TO_MAIN = 40;
  localparam int TO_SHORT = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     req = 3'b000;
  logic [3*W-1:0] xs_bus = '0, ys_bus = '0, xe_bus = '0, ye_bus = '0;
  logic           bpv = 1'b0;
  logic [W-1:0]   bx = '0, by = '0;
  logic           bdone = 1'b0;

  logic [2:0]     gnt, done, pos_valid;
  logic           timeout, bren_start, bren_abort;
  logic [W-1:0]   x0, y0, x1, y1, xpos, ypos;

  logic [2:0]     gnt8, done8, pv8;
  logic           to8, start8, abort8;
  logic [W-1:0]   x0_8, y0_8, x1_8, y1_8, xp8, yp8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  missile_bren_arbiter #(.OUT_WIDTH(W), .TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .xstart_bus(xs_bus), .ystart_bus(ys_bus), .xend_bus(xe_bus), .yend_bus(ye_bus),
    .gnt(gnt), .done(done), .timeout(timeout), .bren_start(bren_start),
    .bren_abort(bren_abort), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .bren_point_valid(bpv), .bren_x(bx), .bren_y(by), .bren_done(bdone),
    .pos_valid(pos_valid), .xpos(xpos), .ypos(ypos)
  );

  missile_bren_arbiter #(.OUT_WIDTH(W), .TIMEOUT(TO_SHORT)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .xstart_bus(xs_bus), .ystart_bus(ys_bus), .xend_bus(xe_bus), .yend_bus(ye_bus),
    .gnt(gnt8), .done(done8), .timeout(to8), .bren_start(start8),
    .bren_abort(abort8), .x0(x0_8), .y0(y0_8), .x1(x1_8), .y1(y1_8),
    .bren_point_valid(bpv), .bren_x(bx), .bren_y(by), .bren_done(bdone),
    .pos_valid(pv8), .xpos(xp8), .ypos(yp8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [2:0] g);
    case (g)
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  // Distinct coordinates per (record, slot, axis) so a wrong slice is visible.
  function automatic logic [7:0] coord(input int c, input int r, input int i);
    case (c)
      0:       return 8'(r * 20 + i * 3 + 1);
      1:       return 8'(200 - r * 7 - i);
      2:       return 8'(r * 11 + i * 5 + 100);
      default: return 8'(r * 3 + i * 9 + 30);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000; bdone = 1'b0; bpv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction on the main DUT starting from IDLE.
  // kind 0: engine completes; kind 1: requester drops req.
  task automatic run_txn(input logic [2:0] rq, input logic [23:0] xsb, input logic [23:0] ysb,
                         input logic [23:0] xeb, input logic [23:0] yeb, input logic [31:0] exp_ep,
                         input int kind, input int hold, input logic [2:0] egnt, input string tag);
    @(negedge clk);
    req = rq; xs_bus = xsb; ys_bus = ysb; xe_bus = xeb; ye_bus = yeb;
    @(negedge clk);
    chk({tag, "_gnt"}, 64'(gnt), 64'(egnt));
    chk({tag, "_start"}, 64'(bren_start), 64'd1);
    chk({tag, "_endpoints"}, 64'({x0, y0, x1, y1}), 64'(exp_ep));
    xs_bus = 24'($urandom); ys_bus = 24'($urandom);
    xe_bus = 24'($urandom); ye_bus = 24'($urandom);
    @(negedge clk);
    chk({tag, "_start_pulse"}, 64'({bren_start, gnt}), 64'({1'b0, egnt}));
    repeat (hold - 1) @(negedge clk);
    if (kind == 0) bdone = 1'b1;
    else req = 3'b000;
    @(negedge clk);
    chk({tag, "_end"}, 64'({done, bren_abort, timeout, gnt}),
        64'({(kind == 0) ? egnt : 3'b000, (kind == 1), 1'b0, 3'b000}));
    chk({tag, "_hold_ep"}, 64'({x0, y0, x1, y1}), 64'(exp_ep));
    bdone = 1'b0; req = 3'b000;
    @(negedge clk);
    chk({tag, "_clear"}, 64'({done, bren_abort, timeout, bren_start}), 64'd0);
  endtask

  typedef struct {
    logic [2:0] req;
    int         kind;
    int         hold;
    logic [2:0] exp_gnt;
  } vec_t;

  // ---------------- reference model (transaction level) ----------------
  int         m_ptr, m_own, m_age;
  bit         m_busy, m_cool;
  logic [2:0] e_gnt, e_done, e_pv;
  logic       e_to, e_start, e_abort;
  logic [7:0] e_x0, e_y0, e_x1, e_y1, e_xp, e_yp;

  task automatic model_reset();
    m_ptr = 0; m_own = 0; m_age = 0; m_busy = 0; m_cool = 0;
    e_gnt = 0; e_done = 0; e_pv = 0; e_to = 0; e_start = 0; e_abort = 0;
    e_x0 = 0; e_y0 = 0; e_x1 = 0; e_y1 = 0; e_xp = 0; e_yp = 0;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit found;
    e_pv = e_gnt & {3{bpv}};
    e_xp = bx; e_yp = by;
    e_done = 0; e_to = 0; e_start = 0; e_abort = 0;
    if (m_cool) begin
      m_cool = 0;
      m_ptr  = (m_own + 1) % 3;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (!found && req[c]) begin
          found = 1; m_own = c;
        end
      end
      if (found) begin
        e_gnt = 3'b001 << m_own;
        e_x0 = xs_bus[m_own*8 +: 8]; e_y0 = ys_bus[m_own*8 +: 8];
        e_x1 = xe_bus[m_own*8 +: 8]; e_y1 = ye_bus[m_own*8 +: 8];
        e_start = 1; m_busy = 1; m_age = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      // m_age-1 equals the number of earlier RUN cycles in this flight.
      if (bdone) begin
        e_done = 3'b001 << m_own;
        e_gnt = 0; m_busy = 0; m_cool = 1;
      end else if (!req[m_own]) begin
        e_abort = 1;
        e_gnt = 0; m_busy = 0; m_cool = 1;
      end else if (m_age - 1 == TO_MAIN) begin
        e_abort = 1; e_to = 1;
        e_gnt = 0; m_busy = 0; m_cool = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    vec_t tbl[10];
    int   t_d;
    int   b;
    int   had8;

    tbl[0] = '{3'b111, 0, 1, 3'b001};
    tbl[1] = '{3'b111, 0, 3, 3'b010};
    tbl[2] = '{3'b011, 0, 2, 3'b001};
    tbl[3] = '{3'b010, 1, 4, 3'b010};
    tbl[4] = '{3'b111, 0, 1, 3'b100};
    tbl[5] = '{3'b110, 1, 6, 3'b010};
    tbl[6] = '{3'b011, 0, 2, 3'b001};
    tbl[7] = '{3'b101, 0, 1, 3'b100};
    tbl[8] = '{3'b100, 0, 5, 3'b100};
    tbl[9] = '{3'b010, 0, 3, 3'b010};

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    chk("reset_main", 64'({gnt, done, timeout, bren_start, bren_abort, x0, y0, x1, y1,
                          pos_valid, xpos, ypos}), 64'd0);
    chk("reset_short", 64'({gnt8, done8, to8, start8, abort8, x0_8, y0_8, x1_8, y1_8,
                           pv8, xp8, yp8}), 64'd0);
    rst_n = 1'b1;

    // Single request with the engine finishing 20 cycles after start.
    run_txn(3'b001, {16'hAAAA, 8'd10}, {16'h5555, 8'd200}, {16'h1234, 8'd120},
            {16'h4321, 8'd30}, {8'd10, 8'd200, 8'd120, 8'd30}, 0, 20, 3'b001, "single");

    // Table of transactions from a fresh pointer.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      logic [23:0] xsb, ysb, xeb, yeb;
      int w;
      for (int i = 0; i < 3; i++) begin
        xsb[i*8 +: 8] = coord(0, r, i); ysb[i*8 +: 8] = coord(1, r, i);
        xeb[i*8 +: 8] = coord(2, r, i); yeb[i*8 +: 8] = coord(3, r, i);
      end
      w = idx_of(tbl[r].exp_gnt);
      run_txn(tbl[r].req, xsb, ysb, xeb, yeb,
              {coord(0, r, w), coord(1, r, w), coord(2, r, w), coord(3, r, w)},
              tbl[r].kind, tbl[r].hold, tbl[r].exp_gnt, $sformatf("tbl%0d", r));
    end

    // Round robin with req=111 held, engine finishing after 5 cycles.
    do_reset();
    @(negedge clk);
    req = 3'b111;
    t_d = 0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] eg;
      eg = (i == 1) ? 3'b010 : (i == 2) ? 3'b100 : 3'b001;
      b = 0;
      @(negedge clk);
      while (gnt == 3'b000 && b < 10) begin
        @(negedge clk);
        b++;
      end
      chk($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(eg));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(cyc - t_d), 64'd2);
      repeat (4) @(negedge clk);
      bdone = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_done%0d", i), 64'(done), 64'(eg));
      t_d = cyc;
      bdone = 1'b0;
    end
    req = 3'b000;

    // Timeout on the short-timeout instance, no engine completion.
    do_reset();
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    chk("to_gnt", 64'(gnt8), 64'b001);
    had8 = 0;
    repeat (9) begin
      @(negedge clk);
      if (to8 || abort8 || gnt8 != 3'b001) had8++;
    end
    chk("to_early", 64'(had8), 64'd0);
    @(negedge clk);
    chk("to_fire", 64'({to8, abort8, gnt8, done8}), 64'({1'b1, 1'b1, 3'b000, 3'b000}));
    chk("to_main_quiet", 64'({timeout, gnt}), 64'({1'b0, 3'b001}));
    @(negedge clk);
    chk("to_clear", 64'({to8, abort8}), 64'd0);
    req = 3'b000;

    // Point routing to requester 2, then a strobe while idle.
    do_reset();
    @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    chk("pt_gnt", 64'(gnt), 64'b100);
    bpv = 1'b1; bx = 8'd50; by = 8'd60;
    @(negedge clk);
    chk("pt_first", 64'({pos_valid, xpos, ypos}), 64'({3'b100, 8'd50, 8'd60}));
    bx = 8'd51; by = 8'd61;
    @(negedge clk);
    chk("pt_second", 64'({pos_valid, xpos, ypos}), 64'({3'b100, 8'd51, 8'd61}));
    bpv = 1'b0; bdone = 1'b1;
    @(negedge clk);
    bdone = 1'b0; req = 3'b000;
    bpv = 1'b1; bx = 8'd70; by = 8'd80;
    @(negedge clk);
    chk("pt_idle_drop", 64'({pos_valid, xpos}), 64'({3'b000, 8'd70}));
    bpv = 1'b0;

    // Asynchronous reset in the middle of a flight.
    do_reset();
    run_txn(3'b001, 24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A,
            {8'h01, 8'h04, 8'h07, 8'h0A}, 0, 2, 3'b001, "pre_rst");
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    chk("ar_gnt", 64'(gnt), 64'b010);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cleared", 64'({gnt, done, timeout, bren_start, bren_abort, x0, y0, x1, y1,
                          pos_valid, xpos, ypos}), 64'd0);
    @(negedge clk);
    chk("ar_no_abort", 64'({bren_abort, gnt}), 64'd0);
    rst_n = 1'b1; req = 3'b111;
    @(negedge clk);
    chk("ar_first_gnt", 64'({gnt, bren_abort}), 64'({3'b001, 1'b0}));
    bdone = 1'b1;
    repeat (2) @(negedge clk);
    bdone = 1'b0; req = 3'b000;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    req = 3'($urandom);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      bdone  = ($urandom_range(0, 19) == 0);
      bpv    = 1'($urandom);
      bx     = 8'($urandom); by = 8'($urandom);
      xs_bus = 24'($urandom); ys_bus = 24'($urandom);
      xe_bus = 24'($urandom); ye_bus = 24'($urandom);
      @(negedge clk);
      model_step();
      chk("rand", 64'({gnt, done, timeout, bren_start, bren_abort, x0, y0, x1, y1,
                       pos_valid, xpos, ypos}),
          64'({e_gnt, e_done, e_to, e_start, e_abort, e_x0, e_y0, e_x1, e_y1,
               e_pv, e_xp, e_yp}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
